// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Staged reset sequencer sitting between the clock generator and the SoC.
//   After rst_sys_n releases (or after a software/watchdog request seen in
//   RUN) both resets are held low for HOLD_CYCLES, then the peripheral reset
//   is released, and STAGE_GAP cycles later the core reset is released.
//   Requests that arrive while a sequence is in progress are ignored.
//
// Parameters
//   HOLD_CYCLES  cycles both resets stay low after entering HOLD (1..2^CNT_W-1)
//   STAGE_GAP    cycles between peripheral and core release   (1..2^CNT_W-1)
//   CNT_W        sequencing counter width
//
// Ports
//   clk_sys       in   system clock, rising edge
//   rst_sys_n     in   synchronous active-low reset (PLL lock AND board reset)
//   sw_rst_req    in   software reset request, level-sampled
//   wdog_rst_req  in   watchdog reset request, level-sampled
//   rst_periph_n  out  peripheral reset, active-low, registered
//   rst_core_n    out  core reset, active-low, registered
//   seq_busy      out  high while the sequence has not reached RUN, registered
//   rst_cause     out  {wdog, sw, por} cause of the last sequence, registered
//
// Configuration
//   RSTSEQ_CAUSE_EN  when defined, rst_cause is a register (3'b001 after
//                    rst_sys_n, loaded with {wdog, sw, 0} on RUN->HOLD);
//                    when undefined, rst_cause is tied to 3'b000.

module rst_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       sw_rst_req,
  input  logic       wdog_rst_req,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       seq_busy,
  output logic [2:0] rst_cause
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             periph_nxt;
  logic             core_nxt;
  logic             busy_nxt;
  logic             restart;

  // Any request sampled in RUN restarts the sequence; elsewhere it is ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    restart   = 1'b0;
    unique case (state)
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      RUN: begin
        if (sw_rst_req | wdog_rst_req) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          restart   = 1'b1;
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output flops are loaded from the decoded next state so that each reset
  // toggles on the same edge as the state change that causes it.
  always_comb begin
    periph_nxt = 1'b0;
    core_nxt   = 1'b0;
    busy_nxt   = 1'b1;
    unique case (state_nxt)
      HOLD: begin
        periph_nxt = 1'b0;
        core_nxt   = 1'b0;
        busy_nxt   = 1'b1;
      end
      GAP: begin
        periph_nxt = 1'b1;
        core_nxt   = 1'b0;
        busy_nxt   = 1'b1;
      end
      RUN: begin
        periph_nxt = 1'b1;
        core_nxt   = 1'b1;
        busy_nxt   = 1'b0;
      end
      default: begin
        periph_nxt = 1'b0;
        core_nxt   = 1'b0;
        busy_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state        <= HOLD;
      cnt          <= '0;
      rst_periph_n <= 1'b0;
      rst_core_n   <= 1'b0;
      seq_busy     <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rst_periph_n <= periph_nxt;
      rst_core_n   <= core_nxt;
      seq_busy     <= busy_nxt;
    end
  end

`ifdef RSTSEQ_CAUSE_EN
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      rst_cause <= 3'b001;
    end else if (restart) begin
      rst_cause <= {wdog_rst_req, sw_rst_req, 1'b0};
    end
  end
`else
  logic unused_restart;
  assign unused_restart = restart;
  assign rst_cause      = 3'b000;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  localparam int unsigned NUM_DUT = 2;
  localparam int unsigned HA = 16;
  localparam int unsigned GA = 8;
  localparam int unsigned HB = 1;
  localparam int unsigned GB = 1;

`ifdef RSTSEQ_CAUSE_EN
  localparam logic [2:0] CAUSE_POR = 3'b001;
  localparam bit         CAUSE_ON  = 1'b1;
`else
  localparam logic [2:0] CAUSE_POR = 3'b000;
  localparam bit         CAUSE_ON  = 1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_sys_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdog_rst_req = 1'b0;

  logic       periph_a, core_a, busy_a;
  logic [2:0] cause_a;
  logic       periph_b, core_b, busy_b;
  logic [2:0] cause_b;

  always #5 clk_sys = ~clk_sys;

  rst_sequencer #(.HOLD_CYCLES(HA), .STAGE_GAP(GA), .CNT_W(8)) u_dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .sw_rst_req   (sw_rst_req),
    .wdog_rst_req (wdog_rst_req),
    .rst_periph_n (periph_a),
    .rst_core_n   (core_a),
    .seq_busy     (busy_a),
    .rst_cause    (cause_a)
  );

  rst_sequencer #(.HOLD_CYCLES(HB), .STAGE_GAP(GB), .CNT_W(8)) u_dut_min (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .sw_rst_req   (sw_rst_req),
    .wdog_rst_req (wdog_rst_req),
    .rst_periph_n (periph_b),
    .rst_core_n   (core_b),
    .seq_busy     (busy_b),
    .rst_cause    (cause_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: elapsed edges since the sequence (re)started, saturating
  // once both resets are released. Outputs follow from thresholds on it.
  int unsigned m_hold [NUM_DUT];
  int unsigned m_gap  [NUM_DUT];
  int unsigned m_t    [NUM_DUT];
  logic [2:0]  m_cause[NUM_DUT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input logic rst_n, input logic sw, input logic wd);
    for (int i = 0; i < NUM_DUT; i++) begin
      int unsigned total;
      total = m_hold[i] + m_gap[i];
      if (!rst_n) begin
        m_t[i]     = 0;
        m_cause[i] = CAUSE_POR;
      end else if (m_t[i] >= total) begin
        if (sw | wd) begin
          m_t[i] = 0;
          if (CAUSE_ON) m_cause[i] = {wd, sw, 1'b0};
        end
      end else begin
        m_t[i] = m_t[i] + 1;
      end
    end
  endtask

  task automatic check_all();
    logic exp_p, exp_c, exp_b;
    for (int i = 0; i < NUM_DUT; i++) begin
      exp_p = (m_t[i] >= m_hold[i]);
      exp_c = (m_t[i] >= m_hold[i] + m_gap[i]);
      exp_b = !exp_c;
      if (i == 0) begin
        check("a_periph", 32'(periph_a), 32'(exp_p));
        check("a_core",   32'(core_a),   32'(exp_c));
        check("a_busy",   32'(busy_a),   32'(exp_b));
        check("a_cause",  32'(cause_a),  32'(m_cause[i]));
      end else begin
        check("b_periph", 32'(periph_b), 32'(exp_p));
        check("b_core",   32'(core_b),   32'(exp_c));
        check("b_busy",   32'(busy_b),   32'(exp_b));
        check("b_cause",  32'(cause_b),  32'(m_cause[i]));
      end
    end
  endtask

  // One clock edge with the given inputs; compare #1 after the edge.
  task automatic step(input logic rst_n, input logic sw, input logic wd);
    rst_sys_n    = rst_n;
    sw_rst_req   = sw;
    wdog_rst_req = wd;
    @(posedge clk_sys);
    model_edge(rst_n, sw, wd);
    #1;
    check_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    m_hold[0] = HA; m_gap[0] = GA;
    m_hold[1] = HB; m_gap[1] = GB;
    for (int i = 0; i < NUM_DUT; i++) begin
      m_t[i] = 0;
      m_cause[i] = CAUSE_POR;
    end

    // Power-up with a request in GAP of the default instance (edge 20).
    repeat (3) step(1'b0, 1'b0, 1'b0);
    idle(19);
    step(1'b1, 1'b0, 1'b1);
    idle(10);

    // Single-cycle software request in RUN.
    step(1'b1, 1'b1, 1'b0);
    idle(30);

    // Simultaneous requests held for 40 cycles, then released.
    repeat (40) step(1'b1, 1'b1, 1'b1);
    idle(30);

    // Watchdog-only request.
    step(1'b1, 1'b0, 1'b1);
    idle(30);

    // Reset dropped mid-sequence at edge 10 for 3 cycles.
    repeat (2) step(1'b0, 1'b0, 1'b0);
    idle(9);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    idle(30);

    // Random traffic: sparse requests and occasional reset pulses.
    for (int k = 0; k < 3000; k++) begin
      logic r, s, w;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 15) == 0);
      w = ($urandom_range(0, 19) == 0);
      step(r, s, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
